// File: rtl/md5_digest_engine_if.sv
// Request/response bundle between the cracker and one MD5 engine.
interface md5_digest_engine_if;
  logic [63:0]  message;
  logic         new_message;
  logic [127:0] digest;
  logic [63:0]  value;
  logic         valid;
  logic         busy;

  modport master (
    output message,
    output new_message,
    input  digest,
    input  value,
    input  valid,
    input  busy
  );

  modport slave (
    input  message,
    input  new_message,
    output digest,
    output value,
    output valid,
    output busy
  );
endinterface

// File: rtl/md5_digest_engine.sv
// Iterative single-block MD5 engine for fixed 8-byte messages: one round per clock,
// 65 clocks from accept to a one-cycle valid pulse carrying digest and source message.
module md5_digest_engine (
  input logic               clk,
  input logic               reset_n,
  md5_digest_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFinal} state_e;

  localparam logic [31:0] InitA = 32'h67452301;
  localparam logic [31:0] InitB = 32'hefcdab89;
  localparam logic [31:0] InitC = 32'h98badcfe;
  localparam logic [31:0] InitD = 32'h10325476;

  localparam logic [31:0] RoundK [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amount repeats every 4 rounds within each 16-round group: index {group, i mod 4}.
  localparam logic [4:0] RoundS [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_e       r_state, w_state_next;
  logic [5:0]   r_round, w_round_next;
  logic [31:0]  r_a, r_b, r_c, r_d;
  logic [31:0]  w_a_next, w_b_next, w_c_next, w_d_next;
  // Only M0/M1 carry message bytes; the padding words are constants.
  logic [31:0]  r_m0, r_m1, w_m0_next, w_m1_next;
  logic [63:0]  r_value_q, w_value_q_next;
  logic [127:0] r_digest, w_digest_next;
  logic [63:0]  r_value, w_value_next;
  logic         r_valid, w_valid_next;
  logic         r_busy, w_busy_next;

  logic         w_ready;
  logic [3:0]   w_i4;
  logic [3:0]   w_g;
  logic [31:0]  w_f;
  logic [31:0]  w_mg;
  logic [31:0]  w_sum;
  logic [4:0]   w_s;
  logic [31:0]  w_rot;
  logic [31:0]  w_new_b;

  assign w_ready = (r_state == StIdle) || r_valid;
  assign w_i4    = r_round[3:0];

  // Round function and message word index; g only depends on i mod 16 since 16 | multipliers.
  always_comb begin
    w_f = 32'h0;
    w_g = 4'h0;
    unique case (r_round[5:4])
      2'd0: begin
        w_f = (r_b & r_c) | (~r_b & r_d);
        w_g = w_i4;
      end
      2'd1: begin
        w_f = (r_d & r_b) | (~r_d & r_c);
        w_g = w_i4 * 4'd5 + 4'd1;
      end
      2'd2: begin
        w_f = r_b ^ r_c ^ r_d;
        w_g = w_i4 * 4'd3 + 4'd5;
      end
      default: begin
        w_f = r_c ^ (r_b | ~r_d);
        w_g = w_i4 * 4'd7;
      end
    endcase
  end

  // Padded block word select: b8 = 0x80 lands in M2, bit length 64 in M14.
  always_comb begin
    w_mg = 32'h0;
    case (w_g)
      4'd0:    w_mg = r_m0;
      4'd1:    w_mg = r_m1;
      4'd2:    w_mg = 32'h0000_0080;
      4'd14:   w_mg = 32'h0000_0040;
      default: w_mg = 32'h0;
    endcase
  end

  assign w_sum   = r_a + w_f + RoundK[r_round] + w_mg;
  assign w_s     = RoundS[{r_round[5:4], r_round[1:0]}];
  assign w_rot   = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));
  assign w_new_b = r_b + w_rot;

  // Next-state logic: accept, iterate rounds, publish result.
  always_comb begin
    w_state_next   = r_state;
    w_round_next   = r_round;
    w_a_next       = r_a;
    w_b_next       = r_b;
    w_c_next       = r_c;
    w_d_next       = r_d;
    w_m0_next      = r_m0;
    w_m1_next      = r_m1;
    w_value_q_next = r_value_q;
    w_digest_next  = r_digest;
    w_value_next   = r_value;
    w_valid_next   = 1'b0;
    w_busy_next    = r_busy;
    unique case (r_state)
      StIdle: begin
        if (bus.new_message && w_ready) begin
          w_value_q_next = bus.message;
          // Little-endian words with the first character as byte 0.
          w_m0_next      = bswap(bus.message[63:32]);
          w_m1_next      = bswap(bus.message[31:0]);
          w_a_next       = InitA;
          w_b_next       = InitB;
          w_c_next       = InitC;
          w_d_next       = InitD;
          w_round_next   = 6'd0;
          w_busy_next    = 1'b1;
          w_state_next   = StRun;
        end
      end
      StRun: begin
        w_a_next     = r_d;
        w_d_next     = r_c;
        w_c_next     = r_b;
        w_b_next     = w_new_b;
        w_round_next = r_round + 6'd1;
        if (r_round == 6'd63) begin
          w_state_next = StFinal;
        end
      end
      default: begin
        w_digest_next = {bswap(r_a + InitA), bswap(r_b + InitB),
                         bswap(r_c + InitC), bswap(r_d + InitD)};
        w_value_next  = r_value_q;
        w_valid_next  = 1'b1;
        w_busy_next   = 1'b0;
        w_state_next  = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops any in-flight hash.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_round   <= 6'd0;
      r_a       <= 32'h0;
      r_b       <= 32'h0;
      r_c       <= 32'h0;
      r_d       <= 32'h0;
      r_m0      <= 32'h0;
      r_m1      <= 32'h0;
      r_value_q <= 64'h0;
      r_digest  <= 128'h0;
      r_value   <= 64'h0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_round   <= w_round_next;
      r_a       <= w_a_next;
      r_b       <= w_b_next;
      r_c       <= w_c_next;
      r_d       <= w_d_next;
      r_m0      <= w_m0_next;
      r_m1      <= w_m1_next;
      r_value_q <= w_value_q_next;
      r_digest  <= w_digest_next;
      r_value   <= w_value_next;
      r_valid   <= w_valid_next;
      r_busy    <= w_busy_next;
    end
  end

  assign bus.digest = r_digest;
  assign bus.value  = r_value;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_md5_digest_engine.sv
// Directed and randomized checks of md5_digest_engine against a straight-line MD5 model.
module tb_md5_digest_engine;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  logic [31:0] k_tab [64];
  int          s_grp [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                                '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  md5_digest_engine_if bus ();

  md5_digest_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reference MD5 of an 8-character message, built byte by byte from the algorithm definition.
  function automatic logic [127:0] md5_model(input logic [63:0] msg);
    logic [7:0]  blk [64];
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, f, tmp;
    int          g;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < 8; i++) blk[i] = msg[63 - 8 * i -: 8];
    blk[8]  = 8'h80;
    blk[56] = 8'h40;
    for (int j = 0; j < 16; j++) w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    a = 32'h67452301;
    b = 32'hefcdab89;
    c = 32'h98badcfe;
    d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        f = (b & c) | (~b & d);
        g = i;
      end else if (i < 32) begin
        f = (d & b) | (~d & c);
        g = (5 * i + 1) % 16;
      end else if (i < 48) begin
        f = b ^ c ^ d;
        g = (3 * i + 5) % 16;
      end else begin
        f = c ^ (b | ~d);
        g = (7 * i) % 16;
      end
      tmp = d;
      d   = c;
      c   = b;
      b   = b + rotl(a + f + k_tab[i] + w[g], s_grp[i / 16][i % 4]);
      a   = tmp;
    end
    return {bswap(a + 32'h67452301), bswap(b + 32'hefcdab89),
            bswap(c + 32'h98badcfe), bswap(d + 32'h10325476)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse new_message for one cycle; returns at the negedge after the accept edge.
  task automatic send(input logic [63:0] msg);
    bus.message     = msg;
    bus.new_message = 1'b1;
    @(negedge clk);
    bus.new_message = 1'b0;
  endtask

  // Counts edges since accept until valid is seen; -1 if the bound expires.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (bus.valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (bus.valid !== 1'b1) lat = -1;
  endtask

  task automatic run_one(input string tag, input logic [63:0] msg);
    int lat;
    send(msg);
    check({tag, "_busy_rise"}, 128'(bus.busy), 128'(1));
    wait_valid(0, lat);
    check({tag, "_latency"}, 128'(lat), 128'(65));
    check({tag, "_digest"}, bus.digest, md5_model(msg));
    check({tag, "_value"}, 128'(bus.value), 128'(msg));
    check({tag, "_busy_at_valid"}, 128'(bus.busy), 128'(0));
    @(negedge clk);
    check({tag, "_valid_drop"}, 128'(bus.valid), 128'(0));
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [63:0] msg_a;
    logic [63:0] msg_b;
    real         r;

    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      k_tab[i] = 32'(longint'($floor(r * 4294967296.0)));
    end

    reset_n         = 1'b0;
    bus.message     = 64'h0;
    bus.new_message = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_valid", 128'(bus.valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_digest", bus.digest, 128'h0);
    check("rst_value", 128'(bus.value), 128'h0);

    // Known-answer vectors.
    run_one("kat0", "00000000");
    check("kat0_gold", bus.digest, 128'hdd4b21e9ef71e1291183a46b913ae6f2);
    run_one("kat1", "12345678");
    check("kat1_gold", bus.digest, 128'h25d55ad283aa400af464c76d713c07ad);
    run_one("kat2", "53589793");
    check("kat2_gold", bus.digest, 128'he8cd0953abdfde433dfec7faa70df7f6);
    repeat (5) @(negedge clk);
    check("hold_digest", bus.digest, 128'he8cd0953abdfde433dfec7faa70df7f6);
    check("hold_value", 128'(bus.value), 128'("53589793"));

    // Chaining: the second request is raised during the valid cycle of the first.
    send("00000000");
    wait_valid(0, lat);
    check("chain1_latency", 128'(lat), 128'(65));
    check("chain1_digest", bus.digest, 128'hdd4b21e9ef71e1291183a46b913ae6f2);
    check("chain1_value", 128'(bus.value), 128'("00000000"));
    send("12345678");
    check("chain2_busy_rise", 128'(bus.busy), 128'(1));
    check("chain2_valid_drop", 128'(bus.valid), 128'(0));
    wait_valid(0, lat);
    check("chain2_latency", 128'(lat), 128'(65));
    check("chain2_digest", bus.digest, 128'h25d55ad283aa400af464c76d713c07ad);
    check("chain2_value", 128'(bus.value), 128'("12345678"));
    @(negedge clk);

    // A request arriving mid-hash is dropped and does not disturb the running one.
    msg_a = "31415926";
    msg_b = "27182818";
    send(msg_a);
    repeat (30) @(negedge clk);
    send(msg_b);
    wait_valid(31, lat);
    check("ignore_latency", 128'(lat), 128'(65));
    check("ignore_digest", bus.digest, md5_model(msg_a));
    check("ignore_value", 128'(bus.value), 128'(msg_a));
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("ignore_not_queued", 128'(seen), 128'(0));

    // Reset in the middle of the rounds discards the request.
    send("99999999");
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_valid", 128'(bus.valid), 128'(0));
    check("midrst_busy", 128'(bus.busy), 128'(0));
    check("midrst_digest", bus.digest, 128'h0);
    check("midrst_value", 128'(bus.value), 128'h0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.valid === 1'b1) seen++;
    end
    check("midrst_no_valid", 128'(seen), 128'(0));
    run_one("after_rst", "87654321");

    // Random printable candidates.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) msg_a[8*i +: 8] = 8'($urandom_range(32, 126));
      run_one($sformatf("rand%0d", n), msg_a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
